obj_cmd_array: RTL and testbench
================================

# obj_cmd_array

Parametrised array of addressable status objects driven by a valid/ready command port. It is the next generation of the fixed 18-object deserializer-plus-objects arrangement. Objects are numbered 1..NUM_OBJ; address 0 broadcasts. Each object supports set, clear, toggle, timed pulse and write lock. The block sits directly behind the deserializer and drives the per-object status bus to the top level.

## Interface
- NUM_OBJ, 18, number of objects; legal range 1..2**ADDR_W-1.
- ADDR_W, 5, command address width.
- PULSE_LEN, 4, cycles status stays high after a PULSE op; legal range 1..255.
- clk_i  input  1  single clock.
- rst_i  input  1  reset; synchronous, active-high.
- cmd_valid_i  input  1  command present.
- cmd_ready_o  output  1  block can accept a command.
- cmd_addr_i  input  ADDR_W  target object (1..NUM_OBJ); 0 = broadcast.
- cmd_op_i  input  3  op: 000 CLR, 001 SET, 010 TOG, 011 PULSE, 100 LOCK, 101 UNLOCK, 110/111 reserved.
- status_o  output  NUM_OBJ  bit k-1 = status of object k.
- lock_o  output  NUM_OBJ  bit k-1 = lock state of object k.
- err_o  output  1  one-cycle error pulse.

## Operation
- Accept on the rising edge with cmd_valid_i && cmd_ready_o. Otherwise, commands are ignored.
- cmd_ready_o is registered: 0 while rst_i is high and in the first cycle after rst_i falls, then constant 1.
- Per object: status bit, lock bit, pulse counter of width clog2(PULSE_LEN+1).
- CLR/SET: status := 0/1.
  - On an unlocked object, also cancels any running pulse (counter := 0).
- TOG: status := ~status.
  - Cancels any running pulse.
  - TOG during a pulse yields 0.
- PULSE: status := 1 and counter := PULSE_LEN.
  - Counter decrements each later cycle.
  - status := 0 on the edge where the counter reaches 0.
  - PULSE on an already-pulsing object restarts the counter.
- LOCK/UNLOCK: lock := 1/0.
  - Always permitted, even on locked objects.
  - Status and any running pulse are untouched.
- Locked object: CLR/SET/TOG/PULSE are ignored. A running pulse still completes.
- Unicast (addr 1..NUM_OBJ):
  - Op on a locked object → err_o.
  - Out-of-range addr (NUM_OBJ+1..2**ADDR_W-1) → err_o, no state change.
- Broadcast (addr 0):
  - Op applies to every object.
  - Locked objects are silently skipped; no err_o.
  - LOCK/UNLOCK broadcast sets or clears all locks.
- Reserved op (110/111), any address → err_o, no state change.
- Simultaneous pulse expiry and an accepted command to the same object: the command wins.
  - Example: SET on the expiry edge leaves status = 1 with counter 0.

## Timing
- Reset values: status_o = 0, lock_o = 0, err_o = 0, cmd_ready_o = 0. All pulse counters = 0.
- rst_i asserted mid-pulse: clears state on that edge; no residual pulse.
- Latency:
  - status_o/lock_o reflect an accepted command on the cycle after the accepting edge (registered outputs, 1 cycle).
  - err_o is high for exactly the cycle after the accepting edge.
- Throughput: one command per cycle, back-to-back.
- PULSE accepted at edge E: status_o high in cycles E+1..E+PULSE_LEN, low from E+PULSE_LEN+1.
- No combinational path from inputs to outputs.

## Test plan
- Reset and ready: hold rst_i 3 cycles, release.
  - All outputs 0 during reset and in the first post-reset cycle.
  - cmd_ready_o = 1 from the second cycle.
- Unicast basics (NUM_OBJ=18), back-to-back:
  - SET 5 → status_o = 18'h00010.
  - TOG 5 → 18'h0.
  - TOG 18 → 18'h20000.
  - Each result one cycle after its accept.
- Pulse (PULSE_LEN=4):
  - PULSE 3 at edge E → bit 2 high for exactly 4 cycles.
  - PULSE 3 again at E+2 → bit 2 high through E+6.
  - SET 3 at the expiry edge → bit 2 stays 1.
- Lock:
  - LOCK 7, then SET 7 → status unchanged, err_o single-cycle pulse.
  - Broadcast SET → 18'h3FFBF, err_o = 0.
  - UNLOCK 7, SET 7 → 18'h3FFFF.
- Errors:
  - addr 19 SET → err_o pulse, no change.
  - addr 31 → err_o pulse, no change.
  - op 110 to addr 1 → err_o pulse, no change.
  - err_o deasserts after 1 cycle.
- Reset mid-pulse: PULSE 1, assert rst_i at E+2.
  - status_o = 0 from E+3.
  - No reassertion after reset release.
  - lock_o = 0.

Source files
------------

// File: rtl/obj_cmd_if.sv
// Command port of the object array: valid/ready handshake plus address and op.
interface obj_cmd_if #(
    parameter int ADDR_W = 5
);
    logic              cmd_valid_i;
    logic              cmd_ready_o;
    logic [ADDR_W-1:0] cmd_addr_i;
    logic [2:0]        cmd_op_i;

    modport master (
        output cmd_valid_i,
        output cmd_addr_i,
        output cmd_op_i,
        input  cmd_ready_o
    );

    modport slave (
        input  cmd_valid_i,
        input  cmd_addr_i,
        input  cmd_op_i,
        output cmd_ready_o
    );
endinterface

// File: rtl/obj_cmd_array.sv
// Array of NUM_OBJ addressable status objects (numbered 1..NUM_OBJ, address 0
// broadcasts). Each object has a status bit, a lock bit and a pulse down-counter.
// All outputs are registered; a command is visible one cycle after its accept.
module obj_cmd_array #(
    parameter int NUM_OBJ   = 18,
    parameter int ADDR_W    = 5,
    parameter int PULSE_LEN = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    obj_cmd_if.slave           cmd,
    output logic [NUM_OBJ-1:0] status_o,
    output logic [NUM_OBJ-1:0] lock_o,
    output logic               err_o
);

    localparam int CNT_W = $clog2(PULSE_LEN + 1);
    localparam logic [CNT_W-1:0]  PULSE_CNT = CNT_W'(PULSE_LEN);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_OBJ);

    localparam logic [2:0] OP_CLR    = 3'b000;
    localparam logic [2:0] OP_SET    = 3'b001;
    localparam logic [2:0] OP_TOG    = 3'b010;
    localparam logic [2:0] OP_PULSE  = 3'b011;
    localparam logic [2:0] OP_LOCK   = 3'b100;
    localparam logic [2:0] OP_UNLOCK = 3'b101;

    logic               ready_q;
    logic               err_q;
    logic [NUM_OBJ-1:0] status_q;
    logic [NUM_OBJ-1:0] lock_q;
    logic [CNT_W-1:0]   cnt_q [NUM_OBJ];

    logic [NUM_OBJ-1:0] status_d;
    logic [NUM_OBJ-1:0] lock_d;
    logic [CNT_W-1:0]   cnt_d [NUM_OBJ];

    logic               accept;
    logic               reserved;
    logic               stat_op;
    logic               bcast;
    logic               in_range;
    logic               tgt_locked;
    logic [NUM_OBJ-1:0] sel;
    logic               err_d;

    assign cmd.cmd_ready_o = ready_q;
    assign status_o        = status_q;
    assign lock_o          = lock_q;
    assign err_o           = err_q;

    // Command decode: which objects a command addresses and whether it is an error.
    always_comb begin
        accept     = cmd.cmd_valid_i && ready_q;
        reserved   = cmd.cmd_op_i[2] && cmd.cmd_op_i[1];
        stat_op    = !cmd.cmd_op_i[2];
        bcast      = (cmd.cmd_addr_i == '0);
        in_range   = !bcast && (cmd.cmd_addr_i <= LAST_ADDR);
        tgt_locked = 1'b0;
        sel        = '0;
        for (int k = 0; k < NUM_OBJ; k++) begin
            if (cmd.cmd_addr_i == ADDR_W'(k + 1)) begin
                tgt_locked = lock_q[k];
            end
            sel[k] = accept && !reserved &&
                     (bcast || (cmd.cmd_addr_i == ADDR_W'(k + 1)));
        end
        // Broadcast never errors on locked objects; those are simply skipped.
        err_d = accept && (reserved ||
                           (!bcast && !in_range) ||
                           (in_range && stat_op && tgt_locked));
    end

    // Per-object next state: pulse countdown first, then an accepted command
    // overrides it so a command on the expiry edge wins.
    always_comb begin
        status_d = status_q;
        lock_d   = lock_q;
        cnt_d    = cnt_q;
        for (int k = 0; k < NUM_OBJ; k++) begin
            if (cnt_q[k] != '0) begin
                cnt_d[k] = cnt_q[k] - CNT_ONE;
                if (cnt_q[k] == CNT_ONE) begin
                    status_d[k] = 1'b0;
                end
            end
            if (sel[k]) begin
                case (cmd.cmd_op_i)
                    OP_CLR: begin
                        if (!lock_q[k]) begin
                            status_d[k] = 1'b0;
                            cnt_d[k]    = '0;
                        end
                    end
                    OP_SET: begin
                        if (!lock_q[k]) begin
                            status_d[k] = 1'b1;
                            cnt_d[k]    = '0;
                        end
                    end
                    OP_TOG: begin
                        if (!lock_q[k]) begin
                            status_d[k] = !status_q[k];
                            cnt_d[k]    = '0;
                        end
                    end
                    OP_PULSE: begin
                        if (!lock_q[k]) begin
                            status_d[k] = 1'b1;
                            cnt_d[k]    = PULSE_CNT;
                        end
                    end
                    OP_LOCK:   lock_d[k] = 1'b1;
                    OP_UNLOCK: lock_d[k] = 1'b0;
                    default: ;
                endcase
            end
        end
    end

    // Object state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            status_q <= '0;
            lock_q   <= '0;
            for (int k = 0; k < NUM_OBJ; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            status_q <= status_d;
            lock_q   <= lock_d;
            for (int k = 0; k < NUM_OBJ; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    // Ready comes up one edge after reset is released; error is a one-cycle pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_obj_cmd_array.sv
// Directed bench for obj_cmd_array with a deadline-based reference model.
module tb_obj_cmd_array;
    localparam int NUM = 18;
    localparam int AW  = 5;
    localparam int PL  = 4;

    localparam logic [2:0] CLR = 3'd0, SET = 3'd1, TOG = 3'd2, PULSE = 3'd3,
                           LOCK = 3'd4, UNLOCK = 3'd5, RSV6 = 3'd6, RSV7 = 3'd7;

    logic clk = 1'b0;
    logic rst;
    logic [NUM-1:0] status;
    logic [NUM-1:0] lock;
    logic err;

    int total = 0;
    int bad   = 0;

    obj_cmd_if #(.ADDR_W(AW)) bus ();

    obj_cmd_array #(.NUM_OBJ(NUM), .ADDR_W(AW), .PULSE_LEN(PL)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .cmd      (bus),
        .status_o (status),
        .lock_o   (lock),
        .err_o    (err)
    );

    always #5 clk = ~clk;

    // Reference model: each object holds a status bit, a lock bit and the
    // absolute edge number at which a running pulse forces status low.
    int n = 0;
    int ms [NUM];
    int ml [NUM];
    int pend [NUM];
    logic m_err = 1'b0;
    logic m_rdy = 1'b0;
    logic [NUM-1:0] exp_status;
    logic [NUM-1:0] exp_lock;

    task automatic apply(input int k, input int o);
        case (o)
            0: begin ms[k] = 0; pend[k] = -1; end
            1: begin ms[k] = 1; pend[k] = -1; end
            2: begin ms[k] = (ms[k] == 0) ? 1 : 0; pend[k] = -1; end
            3: begin ms[k] = 1; pend[k] = n + PL; end
            4: ml[k] = 1;
            5: ml[k] = 0;
            default: ;
        endcase
    endtask

    always @(posedge clk) begin
        int o, a;
        n = n + 1;
        o = int'(bus.cmd_op_i);
        a = int'(bus.cmd_addr_i);
        if (rst) begin
            for (int k = 0; k < NUM; k++) begin
                ms[k] = 0; ml[k] = 0; pend[k] = -1;
            end
            m_err = 1'b0;
            m_rdy = 1'b0;
        end else begin
            m_err = 1'b0;
            for (int k = 0; k < NUM; k++) begin
                if (pend[k] == n) begin
                    ms[k] = 0; pend[k] = -1;
                end
            end
            if (bus.cmd_valid_i && m_rdy) begin
                if (o >= 6) m_err = 1'b1;
                else if (a == 0) begin
                    for (int k = 0; k < NUM; k++)
                        if (o >= 4 || ml[k] == 0) apply(k, o);
                end
                else if (a > NUM) m_err = 1'b1;
                else if (o < 4 && ml[a-1] != 0) m_err = 1'b1;
                else apply(a - 1, o);
            end
            m_rdy = 1'b1;
        end
        for (int k = 0; k < NUM; k++) begin
            exp_status[k] = (ms[k] != 0);
            exp_lock[k]   = (ml[k] != 0);
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (n > 0) begin
            total = total + 4;
            if (status !== exp_status) begin
                bad++; $display("FAIL status cyc=%0d got=%h want=%h", n, status, exp_status);
            end
            if (lock !== exp_lock) begin
                bad++; $display("FAIL lock cyc=%0d got=%h want=%h", n, lock, exp_lock);
            end
            if (err !== m_err) begin
                bad++; $display("FAIL err cyc=%0d got=%b want=%b", n, err, m_err);
            end
            if (bus.cmd_ready_o !== m_rdy) begin
                bad++; $display("FAIL ready cyc=%0d got=%b want=%b", n, bus.cmd_ready_o, m_rdy);
            end
        end
    end

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, want);
        end
    endtask

    // Present a command at a falling edge; returns after it has been accepted
    // and its result is visible.
    task automatic drive(input logic [2:0] op, input logic [AW-1:0] addr);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_op_i    = op;
        bus.cmd_addr_i  = addr;
        @(negedge clk);
    endtask

    task automatic idle();
        bus.cmd_valid_i = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        bus.cmd_valid_i = 1'b0;
        bus.cmd_op_i    = 3'd0;
        bus.cmd_addr_i  = '0;

        repeat (3) @(negedge clk);
        lit("rst_status", 32'(status), 32'h0);
        lit("rst_ready", 32'(bus.cmd_ready_o), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        lit("ready_up", 32'(bus.cmd_ready_o), 32'h1);

        drive(SET, 5);  lit("set5", 32'(status), 32'h00010);
        drive(TOG, 5);  lit("tog5", 32'(status), 32'h0);
        drive(TOG, 18); lit("tog18", 32'(status), 32'h20000);
        idle();

        drive(PULSE, 3); lit("pulse_e1", 32'(status[2]), 32'h1);
        repeat (3) idle();
        lit("pulse_e4", 32'(status[2]), 32'h1);
        idle();
        lit("pulse_e5", 32'(status[2]), 32'h0);

        drive(PULSE, 3); idle(); drive(PULSE, 3);
        repeat (3) idle();
        lit("restart_e6", 32'(status[2]), 32'h1);
        idle();
        lit("restart_e7", 32'(status[2]), 32'h0);

        drive(PULSE, 3); repeat (3) idle(); drive(SET, 3);
        lit("set_on_expiry", 32'(status[2]), 32'h1);
        repeat (2) idle();
        lit("set_on_expiry_hold", 32'(status[2]), 32'h1);
        drive(CLR, 3);

        drive(PULSE, 2); drive(TOG, 2);
        lit("tog_in_pulse", 32'(status[1]), 32'h0);

        drive(PULSE, 4); drive(LOCK, 4); idle(); idle(); drive(CLR, 4);
        lit("locked_pulse_done", 32'(status[3]), 32'h0);
        lit("locked_clr_err", 32'(err), 32'h1);
        drive(UNLOCK, 4);

        drive(LOCK, 7); lit("lock7", 32'(lock), 32'h00040);
        drive(SET, 7);  lit("set_locked", 32'(status[6]), 32'h0);
        lit("set_locked_err", 32'(err), 32'h1);
        idle();         lit("err_one_cycle", 32'(err), 32'h0);
        drive(SET, 0);  lit("bcast_set", 32'(status), 32'h3FFBF);
        lit("bcast_no_err", 32'(err), 32'h0);
        drive(UNLOCK, 7); drive(SET, 7);
        lit("unlock_set", 32'(status), 32'h3FFFF);

        drive(SET, 19);  lit("addr19_err", 32'(err), 32'h1);
        drive(CLR, 31);  lit("addr31_err", 32'(err), 32'h1);
        drive(RSV6, 1);  lit("rsv6_err", 32'(err), 32'h1);
        drive(RSV7, 0);  lit("rsv7_err", 32'(err), 32'h1);
        lit("err_no_change", 32'(status), 32'h3FFFF);
        idle();          lit("err_clear", 32'(err), 32'h0);
        drive(TOG, 0);   lit("bcast_tog", 32'(status), 32'h0);

        drive(LOCK, 9); drive(PULSE, 1); idle();
        bus.cmd_valid_i = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        lit("midpulse_rst_status", 32'(status), 32'h0);
        lit("midpulse_rst_lock", 32'(lock), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) idle();
        lit("no_reassert", 32'(status), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
